// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of a single-port
// synchronous RAM. After reset, and whenever clr is pulsed while
// arbitrating, it zero-fills the whole RAM.
module ram_rr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_prio;
  logic [1:0]            r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_din_hold;

  logic                  w_arb;
  logic                  w_gnt0;
  logic                  w_gnt1;

  // Grant decision: only in ARB, never while reset or clr is high.
  always_comb begin
    w_arb  = (r_state == ST_ARB) && !reset && !clr;
    w_gnt0 = w_arb && req0 && (!req1 || !r_prio);
    w_gnt1 = w_arb && req1 && (!req0 ||  r_prio);
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign busy    = (r_state == ST_INIT);
  // Pending read returns are suppressed while reset is high; the next
  // reset edge clears them anyway.
  assign rvalid0 = r_rd_pend[0] && !reset;
  assign rvalid1 = r_rd_pend[1] && !reset;
  assign rdata   = ram_dout;

  // RAM port mux: sweep, granted requester, or idle with held address/data.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = r_addr_hold;
    ram_din  = r_din_hold;
    if (reset) begin
      ram_we = 1'b0;
    end else if (r_state == ST_INIT) begin
      ram_we   = 1'b1;
      ram_addr = r_cnt;
      ram_din  = '0;
    end else if (w_gnt0) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_din  = din0;
    end else if (w_gnt1) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_din  = din1;
    end
  end

  // Remember the last driven address/data so idle cycles hold them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_hold <= '0;
      r_din_hold  <= '0;
    end else begin
      r_addr_hold <= ram_addr;
      r_din_hold  <= ram_din;
    end
  end

  // Sequencer state, sweep counter, round-robin pointer and read pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_prio    <= 1'b0;
      r_rd_pend <= '0;
    end else begin
      r_rd_pend <= {w_gnt1 && !we1, w_gnt0 && !we0};
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (clr) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
          end else if (w_gnt0) begin
            r_prio <= 1'b1;
          end else if (w_gnt1) begin
            r_prio <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural read-first RAM.
// Expected read returns go into a queue; a forked monitor pops them when
// rvalid0/rvalid1 appear and checks requester, data and cycle.
module tb_ram_rr_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          busy;
  logic          req0, we0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic          req1, we1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] din1;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [16];
  int            cyc = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy),
    .req0(req0), .we0(we0), .addr0(addr0), .din0(din0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .din1(din1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read, read-first on writes.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drv(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One arbitration cycle: check grants and RAM port, queue the read return.
  task automatic arb_cycle(input logic eg0, input logic eg1, input logic [DW-1:0] ed,
                           input bit push, input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt0"}, gnt0, eg0);
    chk({tag, "_gnt1"}, gnt1, eg1);
    if (eg0) begin
      chk({tag, "_we"}, ram_we, we0);
      chk({tag, "_addr"}, ram_addr, addr0);
      if (we0) chk({tag, "_din"}, ram_din, din0);
      else if (push) q.push_back('{1'b0, ed, cyc + 1});
    end else if (eg1) begin
      chk({tag, "_we"}, ram_we, we1);
      chk({tag, "_addr"}, ram_addr, addr1);
      if (we1) chk({tag, "_din"}, ram_din, din1);
      else if (push) q.push_back('{1'b1, ed, cyc + 1});
    end else begin
      chk({tag, "_we_idle"}, ram_we, 0);
    end
    next_cycle();
  endtask

  task automatic sweep_check(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_we"}, ram_we, 1);
      chk({tag, "_addr"}, ram_addr, i);
      chk({tag, "_din"}, ram_din, 0);
      chk({tag, "_gnt0"}, gnt0, 0);
      chk({tag, "_gnt1"}, gnt1, 0);
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b1;
    clr   = 1'b0;
    // requester 0 holds a read of addr 0 through reset and the sweep
    drv(1, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);

    fork
      forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc < cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL rvalid_missing: expected port %0d data %0h at cyc %0d, rvalid absent",
                   q[0].port, q[0].data, q[0].cyc);
          void'(q.pop_front());
        end
        if (rvalid0 || rvalid1) begin
          if (q.size() == 0 || q[0].cyc != cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL rvalid_unexpected @cyc %0d: rvalid0=%0b rvalid1=%0b, none expected",
                     cyc, rvalid0, rvalid1);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("rvalid_port", {30'd0, rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
            chk("rdata", rdata, e.data);
          end
        end
      end
    join_none

    // Reset: grants and writes forced low even with a request present.
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt0", gnt0, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_rvalid0", rvalid0, 0);
      next_cycle();
    end
    reset = 1'b0;

    // Full zero-fill sweep, request held off.
    sweep_check(16, "sweep");
    // First ARB cycle: held read of addr 0, then read every other address.
    arb_cycle(1, 0, 4'h0, 1, "rd_all0");
    for (int unsigned a = 1; a < 16; a++) begin
      drv(1, 0, a[AW-1:0], 4'd0, 0, 0, 4'd0, 4'd0);
      arb_cycle(1, 0, 4'h0, 1, "rd_all");
    end

    // Write then read back through requester 0.
    drv(1, 1, 4'd3, 4'hA, 0, 0, 4'd0, 4'd0);
    arb_cycle(1, 0, 4'h0, 0, "wr3");
    drv(1, 0, 4'd3, 4'd0, 0, 0, 4'd0, 4'd0);
    arb_cycle(1, 0, 4'hA, 1, "rd3");
    drv(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);
    arb_cycle(0, 0, 4'h0, 0, "idle1");

    // Lone requester 1 read moves priority back to requester 0.
    drv(0, 0, 4'd0, 4'd0, 1, 0, 4'd3, 4'd0);
    arb_cycle(0, 1, 4'hA, 1, "rd3_r1");

    // Contention: alternate 0,1,0,1,0,1.
    drv(1, 0, 4'd3, 4'd0, 1, 0, 4'd0, 4'd0);
    for (int unsigned i = 0; i < 6; i++) begin
      if (i % 2 == 0) arb_cycle(1, 0, 4'hA, 1, "rr");
      else            arb_cycle(0, 1, 4'h0, 1, "rr");
    end
    drv(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);
    arb_cycle(0, 0, 4'h0, 0, "idle2");

    // Simultaneous write (r0) and read (r1) of addr 5: read sees new data.
    drv(1, 1, 4'd5, 4'h7, 1, 0, 4'd5, 4'd0);
    arb_cycle(1, 0, 4'h0, 0, "wr5");
    drv(0, 0, 4'd0, 4'd0, 1, 0, 4'd5, 4'd0);
    arb_cycle(0, 1, 4'h7, 1, "rd5");

    // Write 0xF to addr 9, read it, then clr with requester 1 held.
    drv(1, 1, 4'd9, 4'hF, 0, 0, 4'd0, 4'd0);
    arb_cycle(1, 0, 4'h0, 0, "wr9");
    drv(1, 0, 4'd9, 4'd0, 0, 0, 4'd0, 4'd0);
    arb_cycle(1, 0, 4'hF, 1, "rd9_pre");
    drv(0, 0, 4'd0, 4'd0, 1, 0, 4'd9, 4'd0);
    clr = 1'b1;
    arb_cycle(0, 0, 4'h0, 0, "clr");
    clr = 1'b0;
    sweep_check(16, "clr_sweep");
    arb_cycle(0, 1, 4'h0, 1, "rd9_post");

    // Read granted just before reset: no rvalid, then reset mid-sweep.
    drv(1, 0, 4'd5, 4'd0, 0, 0, 4'd0, 4'd0);
    arb_cycle(1, 0, 4'h0, 0, "rd_lost");
    drv(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_rvalid0", rvalid0, 0);
    chk("rst2_we", ram_we, 0);
    next_cycle();
    reset = 1'b0;
    sweep_check(8, "part_sweep");
    reset = 1'b1;
    @(negedge clk);
    chk("rst3_we", ram_we, 0);
    chk("rst3_gnt0", gnt0, 0);
    next_cycle();
    reset = 1'b0;
    sweep_check(16, "re_sweep");
    drv(1, 0, 4'd3, 4'd0, 0, 0, 4'd0, 4'd0);
    arb_cycle(1, 0, 4'h0, 1, "rd3_final");
    drv(0, 0, 4'd0, 4'd0, 0, 0, 4'd0, 4'd0);
    repeat (3) arb_cycle(0, 0, 4'h0, 0, "tail");

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
